// File: rtl/Modules_pkg.sv
// Shared types for the iterative multiplication unit and the logic that feeds it.
package Modules_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MUL_    = 2'd0,
    MULH_   = 2'd1,
    MULHSU_ = 2'd2,
    MULHU_  = 2'd3
  } mul_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;
endpackage

// File: rtl/mul_unit_scheduler_if.sv
// Request/response bundle between the two requesters, the consumer and mul_unit_scheduler.
interface mul_unit_scheduler_if;
  // valid/ready: a beat moves on an enabled clock edge where valid and ready are both high;
  // req_ready_o is a one-hot grant, and rsp_valid_o with its id/result stays stable until that edge.
  logic [1:0]                    req_valid_i;
  logic [1:0]                    req_ready_o;
  Modules_pkg::mul_ops_e         req0_op_i;
  logic [Modules_pkg::XLEN-1:0]  req0_a_i;
  logic [Modules_pkg::XLEN-1:0]  req0_b_i;
  Modules_pkg::mul_ops_e         req1_op_i;
  logic [Modules_pkg::XLEN-1:0]  req1_a_i;
  logic [Modules_pkg::XLEN-1:0]  req1_b_i;
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic                          rsp_id_o;
  logic [Modules_pkg::XLEN-1:0]  rsp_result_o;

  modport slave (
    input  req_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req1_op_i, req1_a_i, req1_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
  );

  modport master (
    output req_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req1_op_i, req1_a_i, req1_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
  );
endinterface

// File: rtl/mul_unit_scheduler.sv
// Round-robin sharing of the free-running 17-cycle Booth multiplier between two requesters.
// Optional last-result cache enabled by defining MUL_SCHED_REUSE_EN.
module mul_unit_scheduler
  import Modules_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clk_en_i,
  mul_unit_scheduler_if.slave bus,
  output logic [XLEN-1:0]     mul_multiplier_o,
  output logic [XLEN-1:0]     mul_multiplicand_o,
  output mul_ops_e            mul_operation_o,
  input  logic [XLEN-1:0]     mul_result_i,
  input  fu_state_e           mul_state_i,
  output logic                busy_o,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FREE = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_ptr;
  logic            w_ptr_nxt;
  logic [1:0]      w_grant;
  logic            w_capture;
  logic            w_rsp_take;

  logic            w_gnt_id;
  mul_ops_e        w_gnt_op;
  logic [XLEN-1:0] w_gnt_a;
  logic [XLEN-1:0] w_gnt_b;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_result;

  mul_ops_e        r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            r_id;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_result;

  // With both requesters valid the pointer side wins; a lone requester wins outright.
  assign w_gnt_id = (bus.req_valid_i == 2'b11) ? r_ptr : bus.req_valid_i[1];
  assign w_gnt_op = w_gnt_id ? bus.req1_op_i : bus.req0_op_i;
  assign w_gnt_a  = w_gnt_id ? bus.req1_a_i  : bus.req0_a_i;
  assign w_gnt_b  = w_gnt_id ? bus.req1_b_i  : bus.req0_b_i;

`ifdef MUL_SCHED_REUSE_EN
  logic            r_c_valid;
  mul_ops_e        r_c_op;
  logic [XLEN-1:0] r_c_a;
  logic [XLEN-1:0] r_c_b;
  logic [XLEN-1:0] r_c_res;

  assign w_hit        = r_c_valid && (r_c_op == w_gnt_op) && (r_c_a == w_gnt_a) && (r_c_b == w_gnt_b);
  assign w_hit_result = r_c_res;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_c_valid <= 1'b0;
      r_c_op    <= MUL_;
      r_c_a     <= '0;
      r_c_b     <= '0;
      r_c_res   <= '0;
    end else if (clk_en_i && w_capture) begin
      r_c_valid <= 1'b1;
      r_c_op    <= r_op;
      r_c_a     <= r_a;
      r_c_b     <= r_b;
      r_c_res   <= mul_result_i;
    end
  end
`else
  assign w_hit        = 1'b0;
  assign w_hit_result = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant     = 2'b00;
    w_capture   = 1'b0;
    w_rsp_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clk_en_i && (bus.req_valid_i != 2'b00)) begin
          w_grant     = w_gnt_id ? 2'b10 : 2'b01;
          w_ptr_nxt   = ~w_gnt_id;
          w_state_nxt = w_hit ? ST_DONE : ST_WAIT_FREE;
        end
      end
      ST_WAIT_FREE: begin
        if (mul_state_i == FREE) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // The next FREE after the load is the end of that operand's 17-cycle window.
        if (mul_state_i == FREE) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready_i) begin
          w_rsp_take  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
    end else if (clk_en_i) begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op         <= MUL_;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
    end else if (clk_en_i) begin
      if (w_grant != 2'b00) begin
        r_op <= w_gnt_op;
        r_a  <= w_gnt_a;
        r_b  <= w_gnt_b;
        r_id <= w_gnt_id;
      end
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= mul_result_i;
      end else if ((w_grant != 2'b00) && w_hit) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= w_hit_result;
      end else if (w_rsp_take) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  // Operands come straight from the hold registers: the unit's MULHSU mux reads them live.
  assign mul_multiplier_o   = r_a;
  assign mul_multiplicand_o = r_b;
  assign mul_operation_o    = r_op;

  assign bus.req_ready_o  = w_grant;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_id_o     = r_id;
  assign bus.rsp_result_o = r_rsp_result;
  assign busy_o           = (r_state != ST_IDLE);
  assign dbg_state_o      = r_state;

endmodule
